// File: rtl/aes_decrypt.sv
// AES-128 inverse cipher, iterative: one operation per clock, one block in flight.
// A start in IDLE captures the ciphertext and cipher key. The block then expands
// all 11 round keys (10 cycles), applies the initial AddRoundKey with rk[10]
// (1 cycle), runs rounds 9..1 (9 cycles) and finishes with the final round using
// rk[0] (1 cycle). done pulses 21 clocks after start is accepted.
//
// Ports
//   clock   in   1    rising-edge clock
//   rst_n   in   1    asynchronous active-low reset
//   start   in   1    request pulse, only sampled in IDLE
//   din     in   128  ciphertext, byte 0 = din[127:120], column-major state
//   k       in   128  AES-128 cipher key, same byte order
//   dout    out  128  plaintext, held until the next block completes
//   busy    out  1    high from start acceptance until done
//   done    out  1    one-cycle completion pulse

package aes_decrypt_pkg;

  // GF(2^8) multiply, reduction polynomial x^8+x^4+x^3+x+1 (0x11b)
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = a;
    for (int i = 1; i < 8; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

endpackage

// Forward S-box, computed as inverse followed by the affine transform
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  import aes_decrypt_pkg::*;

  logic [7:0] b;

  always_comb begin
    b = gf_inv(a);
    s = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  end
endmodule

// Inverse S-box, computed as inverse affine transform followed by inversion
module aes_inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  import aes_decrypt_pkg::*;

  logic [7:0] b;

  always_comb begin
    b = rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05;
    s = gf_inv(b);
  end
endmodule

// State | meaning
// IDLE   | waiting for start; dout holds the last result
// KEYEXP | rk[cnt] = expand(rk[cnt-1]), cnt = 1..10
// INIT   | state ^= rk[10]
// ROUND  | full inverse round with rk[rnd], rnd = 9..1
// FINAL  | last inverse round (no InvMixColumns) with rk[0] into dout
module aes_decrypt (
  input  logic         clock,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] din,
  input  logic [127:0] k,
  output logic [127:0] dout,
  output logic         busy,
  output logic         done
);
  import aes_decrypt_pkg::*;

  typedef enum logic [2:0] {IDLE, KEYEXP, INIT, ROUND, FINAL} fsm_t;

  fsm_t         fsm;
  logic [127:0] st;
  logic [127:0] rk [0:10];
  logic [3:0]   cnt;
  logic [3:0]   rnd;

  logic [127:0] shifted;
  logic [127:0] sub_bytes;
  logic [127:0] round_val;
  logic [127:0] final_val;
  logic [127:0] rk_prev;
  logic [127:0] rk_next;
  logic [31:0]  rot_word;
  logic [31:0]  sub_word;
  logic [31:0]  temp_word;

  // Row r of column c takes the byte from column (c - r) mod 4
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] x);
    logic [127:0] y;
    y = '0;
    for (int i = 0; i < 16; i++) begin
      y[127-8*i -: 8] = x[127-8*((i % 4) + 4*(((i / 4) - (i % 4) + 4) % 4)) -: 8];
    end
    return y;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] x);
    logic [127:0] y;
    logic [7:0]   a0, a1, a2, a3;
    y = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = x[127-32*c -: 8];
      a1 = x[119-32*c -: 8];
      a2 = x[111-32*c -: 8];
      a3 = x[103-32*c -: 8];
      y[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      y[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      y[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      y[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return y;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Round datapath: InvShiftRows -> 16 inverse S-boxes -> AddRoundKey (-> InvMixColumns)
  assign shifted = inv_shift_rows(st);

  for (genvar i = 0; i < 16; i++) begin : g_inv_sbox
    aes_inv_sbox u_inv_sbox (
      .a (shifted[127-8*i -: 8]),
      .s (sub_bytes[127-8*i -: 8])
    );
  end

  assign round_val = inv_mix_columns(sub_bytes ^ rk[rnd]);
  assign final_val = sub_bytes ^ rk[0];

  // Key schedule step: temp = SubWord(RotWord(w3)) ^ Rcon, then XOR chain
  assign rk_prev  = rk[cnt - 4'd1];
  assign rot_word = {rk_prev[23:0], rk_prev[31:24]};

  for (genvar j = 0; j < 4; j++) begin : g_sbox
    aes_sbox u_sbox (
      .a (rot_word[31-8*j -: 8]),
      .s (sub_word[31-8*j -: 8])
    );
  end

  assign temp_word        = sub_word ^ {rcon(cnt), 24'h000000};
  assign rk_next[127:96]  = rk_prev[127:96] ^ temp_word;
  assign rk_next[95:64]   = rk_prev[95:64]  ^ rk_next[127:96];
  assign rk_next[63:32]   = rk_prev[63:32]  ^ rk_next[95:64];
  assign rk_next[31:0]    = rk_prev[31:0]   ^ rk_next[63:32];

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      fsm  <= IDLE;
      st   <= '0;
      cnt  <= '0;
      rnd  <= '0;
      dout <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      for (int i = 0; i < 11; i++) rk[i] <= '0;
    end else begin
      done <= 1'b0;
      case (fsm)
        IDLE: begin
          if (start) begin
            st    <= din;
            rk[0] <= k;
            busy  <= 1'b1;
            cnt   <= 4'd1;
            fsm   <= KEYEXP;
          end
        end
        KEYEXP: begin
          rk[cnt] <= rk_next;
          if (cnt == 4'd10) fsm <= INIT;
          else              cnt <= cnt + 4'd1;
        end
        INIT: begin
          st  <= st ^ rk[10];
          rnd <= 4'd9;
          fsm <= ROUND;
        end
        ROUND: begin
          st  <= round_val;
          rnd <= rnd - 4'd1;
          if (rnd == 4'd1) fsm <= FINAL;
        end
        FINAL: begin
          dout <= final_val;
          done <= 1'b1;
          busy <= 1'b0;
          fsm  <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decrypt.sv
// Testbench for aes_decrypt. The reference is a byte-array AES-128 forward
// cipher; decryption results are checked by round trip against the plaintext
// the bench chose, plus the published vectors. Expected results go into a
// queue when a start is issued; a monitor on the falling edge pops and checks.
module tb_aes_decrypt;

  logic         clock = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] din;
  logic [127:0] k;
  logic [127:0] dout;
  logic         busy;
  logic         done;

  aes_decrypt dut (
    .clock (clock),
    .rst_n (rst_n),
    .start (start),
    .din   (din),
    .k     (k),
    .dout  (dout),
    .busy  (busy),
    .done  (done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] exp;
    int           e0;
  } exp_t;

  exp_t         sbq[$];
  logic [127:0] held = '0;
  int           checks = 0;
  int           errors = 0;
  logic [7:0]   sbox [256];

  localparam logic [127:0] FIPS_K  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] TEAM_K  = 128'h5468617473206d79204b756e67204675;
  localparam logic [127:0] TEAM_CT = 128'h29c3505f571420f6402299b31a02d73a;
  localparam logic [127:0] TEAM_PT = 128'h54776f204f6e65204e696e652054776f;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // S-box built by walking the multiplicative group with generator 3
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // FIPS-197 forward cipher on a 16-byte array, s[row + 4*col]
  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] out;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r + 4*c] = sbox[s[r + 4*((c + r) % 4)]];
      if (rd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end else begin
        for (int i = 0; i < 16; i++) s[i] = t[i];
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rd + i/4][31-8*(i%4) -: 8];
    end
    out = '0;
    for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
    return out;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Called at posedge+#1; the start is sampled at the next edge (cyc+1)
  task automatic issue(input logic [127:0] ct, input logic [127:0] key, input logic [127:0] exp);
    exp_t e;
    start = 1'b1;
    din   = ct;
    k     = key;
    e.exp = exp;
    e.e0  = cyc + 1;
    sbq.push_back(e);
    @(posedge clock);
    #1;
    start = 1'b0;
    din   = rnd128();
    k     = rnd128();
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 40) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done within 40 cycles (t=%0t)", $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Monitor / scoreboard
  always @(negedge clock) begin
    exp_t e;
    logic exp_busy;
    if (!rst_n) begin
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_dout", dout, 0);
    end else if (done) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: done=1 with nothing outstanding, dout %h (t=%0t)", dout, $time);
      end else begin
        e = sbq.pop_front();
        chk("dout", dout, e.exp);
        chk("latency", cyc - e.e0, 21);
        chk("busy_at_done", busy, 0);
        held = e.exp;
      end
    end else begin
      exp_busy = (sbq.size() > 0) && (cyc >= sbq[0].e0);
      chk("dout_hold", dout, held);
      chk("busy", busy, exp_busy);
    end
  end

  initial begin
    build_sbox();
    rst_n = 1'b0;
    start = 1'b0;
    din   = '0;
    k     = '0;

    chk("model_fips", aes_enc(FIPS_PT, FIPS_K), FIPS_CT);
    chk("model_team", aes_enc(TEAM_PT, TEAM_K), TEAM_CT);

    repeat (3) @(posedge clock);
    #1;
    chk("por_busy", busy, 0);
    chk("por_dout", dout, 0);
    rst_n = 1'b1;

    // First edge after reset release accepts start; then back-to-back team vector
    issue(FIPS_CT, FIPS_K, FIPS_PT);
    wait_done();
    issue(TEAM_CT, TEAM_K, TEAM_PT);
    chk("b2b_first_held", dout, FIPS_PT);
    wait_done();
    chk("team_low16", {112'h0, dout[15:0]}, 128'h776f);
    step();

    // Start pulse while busy must be ignored
    issue(FIPS_CT, FIPS_K, FIPS_PT);
    repeat (4) step();
    chk("busy_mid", busy, 1);
    start = 1'b1;
    din   = TEAM_CT;
    k     = TEAM_K;
    step();
    start = 1'b0;
    wait_done();
    repeat (30) step();

    // Reset during an operation aborts it
    issue(FIPS_CT, FIPS_K, FIPS_PT);
    repeat (14) step();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_dout", dout, 0);
    sbq.delete();
    held = '0;
    repeat (2) step();
    rst_n = 1'b1;
    issue(TEAM_CT, TEAM_K, TEAM_PT);
    wait_done();
    step();

    // Random round trips, mixing back-to-back and idle gaps
    for (int n = 0; n < 1000; n++) begin
      logic [127:0] pt, key;
      int gap;
      pt  = rnd128();
      key = rnd128();
      issue(aes_enc(pt, key), key, pt);
      wait_done();
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) step();
    end

    repeat (30) step();
    chk("queue_empty", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_decrypt.md
AES_DECRYPT -- requirements
Module: aes_decrypt

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-002 clock  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  request pulse, sampled only in IDLE.
REQ-005 din  in  128  ciphertext block; byte 0 = din[127:120]; state loaded column-major.
REQ-006 k  in  128  AES-128 cipher key (round-0 key); same byte order as din.
REQ-007 dout  out  128  recovered plaintext, same byte order.
REQ-008 busy  out  1  high from start acceptance until done.
REQ-009 done  out  1  one-cycle pulse; dout valid from that cycle.

Function
REQ-010 Algorithm SHALL be FIPS-197 AES-128 inverse cipher, iterative: one operation per clock, no pipelining.
REQ-011 FSM states SHALL be IDLE, KEYEXP, INIT, ROUND, FINAL.
REQ-012 IDLE with start=1 SHALL capture din into the state register and k into rk[0], set busy=1, set cnt=1, and go to KEYEXP.
REQ-013 KEYEXP SHALL compute rk[cnt] from rk[cnt-1] each cycle (RotWord, SubWord, Rcon[cnt], XOR chain) and store all 11 round keys in registers; after cnt=10 it SHALL go to INIT.
REQ-014 INIT SHALL set state = state XOR rk[10], set rnd=9, and go to ROUND.
REQ-015 ROUND SHALL set state = InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), rk[rnd])) and decrement rnd; after rnd=1 it SHALL go to FINAL.
REQ-016 FINAL SHALL set dout = AddRoundKey(InvSubBytes(InvShiftRows(state)), rk[0]), pulse done=1 for one cycle, drop busy, and return to IDLE.
REQ-017 Latency SHALL be fixed: start sampled at edge E0 -> done high in the cycle after edge E21 (21 clocks). Throughput SHALL be one block per 22 clocks.
REQ-018 start while busy=1 SHALL be ignored; din and k SHALL be don't-care after E0.
REQ-019 start in the same cycle that done is high SHALL be accepted, because the FSM is already in IDLE.
REQ-020 dout SHALL hold its value until the next FINAL; it SHALL NOT change during a later operation.
REQ-021 InvMixColumns SHALL use GF(2^8) multiplication by 0e/0b/0d/09 with the reduction polynomial 0x11b.
REQ-022 The 16 inverse S-box and 4 forward S-box lookups SHALL be combinational leaf instances.
REQ-023 The round counters SHALL be 4 bits wide; Rcon values SHALL be 01,02,04,08,10,20,40,80,1b,36.

Reset
REQ-024 rst_n=0 SHALL immediately force: FSM to IDLE, busy=0, done=0, dout=0, cnt=0, rnd=0, state=0, and all rk=0.
REQ-025 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after release SHALL behave as from power-up.
REQ-026 The first edge after rst_n rises SHALL be able to accept start.

Verification
REQ-027 FIPS-197 C.1: k=000102030405060708090a0b0c0d0e0f, din=69c4e0d86a7b0430d8cdb78070b4c55a -> dout=00112233445566778899aabbccddeeff, done exactly 21 clocks after start.
REQ-028 Team vector: k=5468617473206d79204b756e67204675, din=29c3505f571420f6402299b31a02d73a -> dout=54776f204f6e65204e696e652054776f, dout[15:0]=776f.
REQ-029 Run case REQ-027, then pulse start with new din at cycle 5 -> the new start is ignored; a single done with the REQ-027 result.
REQ-030 Assert rst_n=0 at cycle 15 of an operation -> busy, done, and dout go to 0 asynchronously; no done pulse; a following REQ-028 run passes.
REQ-031 Back-to-back: start with the REQ-028 vector in the done cycle of REQ-027 -> second done 21 clocks later; first dout held until then.
REQ-032 Round trip: random k and plaintext, encrypt with AES_Encrypt, feed the ciphertext here -> the original plaintext for 1000 vectors.
